imem_loader: RTL

Byte-stream program loader that writes the 256-word instruction memory read by the CPU's fetch stage. It accepts a length byte, 4·N data bytes (MSB first) and a checksum byte over a valid/ready handshake, assembles 32-bit words and writes them from address 0 upward. It holds the CPU in reset through `cpu_rstd` until a load completes with a good checksum. It provides the combinational `pc → ins` read port used by fetch.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader for the 256-word instruction memory.
// Holds the CPU in reset until a load finishes with a matching XOR checksum.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [AW-1:0] pc,
  output logic [31:0]   ins,
  output logic          cpu_rstd,
  output logic          loaded,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]  r_state;
  logic [AW:0] r_n;
  logic [AW:0] r_words;
  logic [23:0] r_word;
  logic [1:0]  r_cnt;
  logic [7:0]  r_csum;
  logic        r_loaded;
  logic        r_err;
  logic [31:0] r_mem [0:DEPTH-1];

  logic        w_accept;
  logic        w_we;
  logic [AW:0] w_words_nxt;

  function automatic logic [7:0] f_csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Ready decode: only the receiving states take bytes
  always_comb begin
    byte_ready = 1'b0;
    case (r_state)
      S_LEN, S_DATA, S_CSUM: byte_ready = 1'b1;
      default:               byte_ready = 1'b0;
    endcase
  end

  assign w_accept    = byte_valid & byte_ready;
  // A write on the reset edge would corrupt memory of an aborted load
  assign w_we        = rstd & w_accept & (r_state == S_DATA) & (r_cnt == 2'd3);
  assign w_words_nxt = r_words + (AW+1)'(1);

  // Load sequencing, checksum accumulation and status flags
  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_state  <= S_IDLE;
      r_n      <= (AW+1)'(0);
      r_words  <= (AW+1)'(0);
      r_word   <= 24'd0;
      r_cnt    <= 2'd0;
      r_csum   <= 8'd0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            r_state  <= S_LEN;
            r_words  <= (AW+1)'(0);
            r_cnt    <= 2'd0;
            r_csum   <= 8'd0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_n     <= (AW+1)'({1'b0, byte_data}) + (AW+1)'(1);
            r_csum  <= byte_data;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word <= {r_word[15:0], byte_data};
            r_csum <= f_csum_step(r_csum, byte_data);
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_words <= w_words_nxt;
              if (w_words_nxt == r_n) begin
                r_state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (byte_data == r_csum) begin
              r_state  <= S_RUN;
              r_loaded <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Instruction memory: never cleared, survives reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_words[AW-1:0]] <= {r_word, byte_data};
    end
  end

  assign ins          = r_mem[pc];
  assign cpu_rstd     = (r_state == S_RUN);
  assign loaded       = r_loaded;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule
